// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 mode constants, colour width and the registered sync flag bundle.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COORD_W  = 12;
  localparam int RGB_W        = 3;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } sync_t;
endpackage

// File: rtl/vga_pattern.sv
// vga_pattern: eight vertical colour bars from an incrementing bar counter, one register stage.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int BAR_W = 80,
  parameter int CNT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic             line_i,
  input  logic             de_i,
  output logic [RGB_W-1:0] r_o,
  output logic [RGB_W-1:0] g_o,
  output logic [RGB_W-1:0] b_o
);
  logic [2:0]       bar_q, bar_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;
  // bar_q/cnt_q describe the pixel currently held in the first timing stage; bar 7 absorbs the remainder
  always_comb begin
    last  = int'(cnt_q) == BAR_W - 1;
    cnt_d = line_i ? '0 : (bar_q == 3'd7) ? cnt_q : last ? '0 : CNT_W'(int'(cnt_q) + 1);
    bar_d = line_i ? '0 : (bar_q != 3'd7 && last) ? bar_q + 3'd1 : bar_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bar_q <= '0;
      cnt_q <= '0;
      r_o   <= '0;
      g_o   <= '0;
      b_o   <= '0;
    end else if (ce_i) begin
      bar_q <= bar_d;
      cnt_q <= cnt_d;
      r_o   <= de_i ? {RGB_W{bar_q[2]}} : '0;
      g_o   <= de_i ? {RGB_W{bar_q[1]}} : '0;
      b_o   <= de_i ? {RGB_W{bar_q[0]}} : '0;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel clock-enable.
// Define VGA_TIMING_PATTERN_EN to add the colour-bar outputs (latency grows from 1 to 2).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COORD_W  = DEF_COORD_W
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Ce,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_De,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_LineStart,
  output logic               o_FrameStart
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [RGB_W-1:0]   o_R,
  output logic [RGB_W-1:0]   o_G,
  output logic [RGB_W-1:0]   o_B
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam sync_t S_RST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, ls: 1'b0, fs: 1'b0};

  if (H_TOTAL > 2 ** COORD_W || V_TOTAL > 2 ** COORD_W) begin : g_bad_coord_w
    $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic [COORD_W-1:0] h_q, h_d, v_q, v_d, x_q, y_q;
  sync_t              s_q, s_d;
  int                 hx, vx;

  always_comb begin
    hx   = int'(h_q);
    vx   = int'(v_q);
    h_d  = (hx == H_TOTAL - 1) ? '0 : COORD_W'(hx + 1);
    v_d  = (hx != H_TOTAL - 1) ? v_q : (vx == V_TOTAL - 1) ? '0 : COORD_W'(vx + 1);
    s_d.hs = (hx >= HS_BEG && hx < HS_END) ? SYNC_POL : ~SYNC_POL;
    s_d.vs = (vx >= VS_BEG && vx < VS_END) ? SYNC_POL : ~SYNC_POL;
    s_d.de = hx < H_ACTIVE && vx < V_ACTIVE;
    s_d.ls = hx == 0;
    s_d.fs = hx == 0 && vx == 0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      h_q <= '0;
      v_q <= '0;
      x_q <= '0;
      y_q <= '0;
      s_q <= S_RST;
    end else if (i_Ce) begin
      h_q <= h_d;
      v_q <= v_d;
      x_q <= h_q;
      y_q <= v_q;
      s_q <= s_d;
    end

`ifdef VGA_TIMING_PATTERN_EN
  logic [COORD_W-1:0] x2_q, y2_q;
  sync_t              s2_q;

  // second stage keeps timing outputs aligned with the registered colour
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      x2_q <= '0;
      y2_q <= '0;
      s2_q <= S_RST;
    end else if (i_Ce) begin
      x2_q <= x_q;
      y2_q <= y_q;
      s2_q <= s_q;
    end

  vga_pattern #(
    .BAR_W ((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1),
    .CNT_W (COORD_W)
  ) u_pattern (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_n),
    .ce_i   (i_Ce),
    .line_i (h_q == '0),
    .de_i   (s_q.de),
    .r_o    (o_R),
    .g_o    (o_G),
    .b_o    (o_B)
  );

  assign o_HSync      = s2_q.hs;
  assign o_VSync      = s2_q.vs;
  assign o_De         = s2_q.de;
  assign o_LineStart  = s2_q.ls;
  assign o_FrameStart = s2_q.fs;
  assign o_x          = x2_q;
  assign o_y          = y2_q;
`else
  assign o_HSync      = s_q.hs;
  assign o_VSync      = s_q.vs;
  assign o_De         = s_q.de;
  assign o_LineStart  = s_q.ls;
  assign o_FrameStart = s_q.fs;
  assign o_x          = x_q;
  assign o_y          = y_q;
`endif
endmodule
